// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: controller state
// encoding and the default operand / iteration-counter widths.
package seq_restoring_divider_pkg;

  // Default operand width and iteration counter width (2**CNT_W must exceed WIDTH)
  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  // Controller states: idle, iterating one quotient bit per clock, and the
  // single-cycle finish state that carries the done pulse
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

endpackage

// File: rtl/ripple_borrow_sub.sv
// Parameterised ripple-borrow subtractor: diff = a - b - bin, built from a
// chain of 1-bit full subtractors. bout=1 means the unsigned result wrapped.
module ripple_borrow_sub
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin
);

  // borrow[i] is the borrow into bit i; borrow[WIDTH] leaves the top bit
  logic [WIDTH:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign diff[i]       = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i + 1] = (~a[i] & b[i]) | (~a[i] & borrow[i]) | (b[i] & borrow[i]);
  end

  assign bout = borrow[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider. One quotient bit is produced per
// clock by trial-subtracting the divisor from the shifted partial remainder
// in a ripple-borrow subtractor and either committing or restoring.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // Counter value seen on the edge that performs the final iteration
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             qbit;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Partial remainder shifted left with the next dividend bit brought in.
  // Its top bit is outside the subtractor: when set, the partial value is
  // already at least 2**WIDTH and therefore certainly exceeds the divisor.
  assign partial = {r_reg, q_reg[WIDTH-1]};

  ripple_borrow_sub #(
    .WIDTH(WIDTH)
  ) u_sub (
    .diff(diff),
    .bout(borrow_out),
    .a   (partial[WIDTH-1:0]),
    .b   (d_reg),
    .bin (1'b0)
  );

  // The trial subtraction succeeds when the partial value is wide enough on
  // its own or the subtractor did not borrow; otherwise restore the remainder
  assign qbit   = partial[WIDTH] | ~borrow_out;
  assign r_next = qbit ? diff : partial[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], qbit};

  // Controller, operand shift registers, iteration counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            cnt   <= '0;
            if (divisor == '0) begin
              state       <= FIN;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            state       <= FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: 8-bit directed vectors with
// hand-computed results, handshake timing, ignored starts, back-to-back
// operation, asynchronous reset mid-run, and exhaustive 5-bit / 4-bit sweeps.
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] dividend8 = '0;
  logic [7:0] divisor8 = '0;
  logic       busy8, done8, div_by_zero8;
  logic [7:0] quotient8, remainder8;

  logic       start5 = 1'b0;
  logic [4:0] dividend5 = '0;
  logic [4:0] divisor5 = '0;
  logic       busy5, done5, div_by_zero5;
  logic [4:0] quotient5, remainder5;

  logic       start4 = 1'b0;
  logic [3:0] dividend4 = '0;
  logic [3:0] divisor4 = '0;
  logic       busy4, done4, div_by_zero4;
  logic [3:0] quotient4, remainder4;

  int checks = 0;
  int errors = 0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
    .div_by_zero(div_by_zero8)
  );

  seq_restoring_divider #(.WIDTH(5), .CNT_W(3)) dut5 (
    .clk(clk), .rst_n(rst_n), .start(start5), .dividend(dividend5), .divisor(divisor5),
    .busy(busy5), .done(done5), .quotient(quotient5), .remainder(remainder5),
    .div_by_zero(div_by_zero5)
  );

  seq_restoring_divider #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dividend4), .divisor(divisor4),
    .busy(busy4), .done(done4), .quotient(quotient4), .remainder(remainder4),
    .div_by_zero(div_by_zero4)
  );

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present operands with a one-cycle start pulse; returns just after edge E0
  task automatic applyStimulus(input int a, input int b);
    dividend8 = 8'(a);
    divisor8  = 8'(b);
    start8    = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  // Count cycles after E0 (sampled on falling edges) until done, bounded
  task automatic waitDone8(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      if (busy8) busy_cycles++;
    end while (!done8 && lat < 40);
  endtask

  // Full 8-bit operation with latency, busy length and result checks
  task automatic runCheck8(input string name, input int a, input int b, input int exp_q,
                           input int exp_r, input int exp_dbz, input int exp_lat,
                           input int exp_busy);
    int lat, busy_cycles;
    applyStimulus(a, b);
    waitDone8(lat, busy_cycles);
    checkOutput({name, " latency"}, lat, exp_lat);
    checkOutput({name, " busy cycles"}, busy_cycles, exp_busy);
    checkOutput({name, " quotient"}, 32'(quotient8), exp_q);
    checkOutput({name, " remainder"}, 32'(remainder8), exp_r);
    checkOutput({name, " div_by_zero"}, 32'(div_by_zero8), exp_dbz);
  endtask

  // Done must drop after its single cycle
  task automatic checkPulseEnd(input string name);
    @(negedge clk);
    checkOutput({name, " done pulse width"}, 32'(done8), 0);
  endtask

  // One operation on the 5-bit or 4-bit instance against a division reference
  task automatic runSmall(input int w, input int a, input int b);
    int lat, q, r, dbz, bsy, exp_q, exp_r, exp_dbz, exp_lat;
    logic seen;
    if (w == 5) begin
      dividend5 = 5'(a); divisor5 = 5'(b); start5 = 1'b1;
    end else begin
      dividend4 = 4'(a); divisor4 = 4'(b); start4 = 1'b1;
    end
    @(posedge clk);
    #1;
    start5 = 1'b0;
    start4 = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      seen = (w == 5) ? done5 : done4;
    end
    if (w == 5) begin
      q = int'(quotient5); r = int'(remainder5); dbz = int'(div_by_zero5); bsy = int'(busy5);
    end else begin
      q = int'(quotient4); r = int'(remainder4); dbz = int'(div_by_zero4); bsy = int'(busy4);
    end
    if (b == 0) begin
      exp_q = (1 << w) - 1; exp_r = a; exp_dbz = 1; exp_lat = 1;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_dbz = 0; exp_lat = w + 1;
    end
    checkOutput($sformatf("w%0d %0d/%0d latency", w, a, b), lat, exp_lat);
    checkOutput($sformatf("w%0d %0d/%0d quotient", w, a, b), q, exp_q);
    checkOutput($sformatf("w%0d %0d/%0d remainder", w, a, b), r, exp_r);
    checkOutput($sformatf("w%0d %0d/%0d div_by_zero", w, a, b), dbz, exp_dbz);
    checkOutput($sformatf("w%0d %0d/%0d busy at done", w, a, b), bsy, 0);
  endtask

  // Directed sequence
  initial begin
    int lat, busy_cycles, done_seen;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy8), 0);
    checkOutput("reset done", 32'(done8), 0);
    checkOutput("reset quotient", 32'(quotient8), 0);
    checkOutput("reset remainder", 32'(remainder8), 0);
    checkOutput("reset div_by_zero", 32'(div_by_zero8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed 8-bit divisions
    runCheck8("200/7", 200, 7, 28, 4, 0, 9, 8);
    checkPulseEnd("200/7");
    runCheck8("255/1", 255, 1, 255, 0, 0, 9, 8);
    checkPulseEnd("255/1");
    runCheck8("255/255", 255, 255, 1, 0, 0, 9, 8);
    checkPulseEnd("255/255");
    runCheck8("128/3", 128, 3, 42, 2, 0, 9, 8);
    checkPulseEnd("128/3");
    runCheck8("5/9", 5, 9, 0, 5, 0, 9, 8);
    checkPulseEnd("5/9");

    // Divide by zero, then a normal operation clears the flag
    runCheck8("100/0", 100, 0, 255, 100, 1, 1, 0);
    checkPulseEnd("100/0");
    runCheck8("10/3", 10, 3, 3, 1, 0, 9, 8);
    checkPulseEnd("10/3");

    // Start during RUN is ignored; results hold the previous values meanwhile
    applyStimulus(50, 5);
    repeat (3) @(negedge clk);
    checkOutput("quotient held during run", 32'(quotient8), 3);
    checkOutput("busy in run cycle 3", 32'(busy8), 1);
    dividend8 = 8'd99;
    divisor8  = 8'd2;
    start8    = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    waitDone8(lat, busy_cycles);
    checkOutput("50/5 remaining latency", lat, 6);
    checkOutput("50/5 quotient", 32'(quotient8), 10);
    checkOutput("50/5 remainder", 32'(remainder8), 0);

    // Start during the done cycle is accepted with no bubble
    runCheck8("99/2 back-to-back", 99, 2, 49, 1, 0, 9, 8);
    checkPulseEnd("99/2");

    // Asynchronous reset in the middle of iteration 4
    applyStimulus(200, 7);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-run reset busy", 32'(busy8), 0);
    checkOutput("mid-run reset done", 32'(done8), 0);
    checkOutput("mid-run reset quotient", 32'(quotient8), 0);
    checkOutput("mid-run reset remainder", 32'(remainder8), 0);
    checkOutput("mid-run reset div_by_zero", 32'(div_by_zero8), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    done_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8 || busy8) done_seen++;
    end
    checkOutput("no activity after reset release", done_seen, 0);
    runCheck8("17/4 after reset", 17, 4, 4, 1, 0, 9, 8);
    checkPulseEnd("17/4");

    // Exhaustive sweeps of the narrow builds
    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        runSmall(5, a, b);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        runSmall(4, a, b);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
